vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised raster timing generator and successor to the fixed 640x480 timing block. Horizontal/vertical geometry, sync polarity and counter width are parameters, so one block covers 640x480@60, 1280x960 and custom modes. Adds a clock enable, line-start and frame-start strobes, and an optional sync/DE delay line that aligns timing with downstream pixel pipelines. Sits between the pixel clock domain and the VGA pin drivers and pixel renderer.

Parameters:
H_DISPW, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_PW, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
H_POL, 0, hsync polarity (0 = active-low, 1 = active-high)
V_DISPW, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_PW, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
V_POL, 0, vsync polarity (0 = active-low, 1 = active-high)
CNT_W, 13, counter width
PIPE_DLY, 2, extra output delay stages; used only with VGA_PIPE_ALIGN_EN

Ports:
PCLK_I  in  1  pixel clock
RST_I  in  1  reset
EN_I  in  1  clock enable; low freezes the whole block
HCNT_O  out  CNT_W  pixel counter, 0..H_TOT-1
VCNT_O  out  CNT_W  line counter, 0..V_TOT-1
DE_O  out  1  high in active video
HSYNC_O  out  1  horizontal sync, polarity per H_POL
VSYNC_O  out  1  vertical sync, polarity per V_POL
LINE_O  out  1  one-cycle strobe at HCNT=0
FRAME_O  out  1  one-cycle strobe at HCNT=0, VCNT=0

Behaviour:
- Interface: one clock, PCLK_I. Reset RST_I is synchronous and active-high.
- Totals: H_TOT = H_DISPW+H_FP+H_PW+H_BP; V_TOT = V_DISPW+V_FP+V_PW+V_BP.
- Elaboration error if H_TOT > 2^CNT_W, V_TOT > 2^CNT_W, or any geometry parameter is 0.
- Reset values: HCNT_O=H_TOT-1, VCNT_O=V_TOT-1, DE_O=0, LINE_O=0, FRAME_O=0. HSYNC_O and VSYNC_O sit at their inactive level (1 when POL=0, 0 when POL=1). All delay-line stages take these same values.
- Reset has priority over EN_I.
- The first enabled cycle after reset shows HCNT=0, VCNT=0.
- Counting (EN_I=1):
  - HCNT increments by 1 and wraps at H_TOT-1 to 0.
  - VCNT increments only on the HCNT wrap, and wraps at V_TOT-1 to 0 when HCNT also wraps.
- Decode (all outputs registered):
  - DE = (HCNT < H_DISPW) and (VCNT < V_DISPW).
  - hsync active when H_DISPW+H_FP <= HCNT <= H_DISPW+H_FP+H_PW-1.
  - vsync active for whole lines with V_DISPW+V_FP <= VCNT <= V_DISPW+V_FP+V_PW-1.
  - LINE = (HCNT==0). FRAME = (HCNT==0 and VCNT==0).
- Alignment: DE, sync and strobe outputs are decoded from the next-count values. They therefore correspond to the HCNT_O/VCNT_O value present in the same cycle, with zero skew.
- EN_I=0: counters, decoded outputs and delay line all hold. LINE_O and FRAME_O are forced to 0, so a strobe is never repeated. Resuming continues from the held count.
- Reset mid-frame: the block returns to the reset values on the next edge, regardless of state.

Optional Feature:
VGA_PIPE_ALIGN_EN
- Defined: DE, HSYNC, VSYNC, LINE and FRAME pass through PIPE_DLY additional registered stages, advancing only while EN_I=1. HCNT_O and VCNT_O are not delayed.
- PIPE_DLY=0 is legal and equals the undefined behaviour.
- Undefined: PIPE_DLY is ignored and outputs are aligned with the counters.

Decomposition:
- Package vga_timing_pkg holds named geometry constant sets for 640x480@60 (800x525 totals) and 1280x960 (H 1280/80/136/216, V 960/1/3/30), plus polarity encodings.
- Sub-module vga_delay_line:
  - parameters WIDTH and DEPTH;
  - ports: clock, reset, enable, a reset-value input and data;
  - instantiated only under VGA_PIPE_ALIGN_EN.

Test Plan:
1. Default parameters, EN_I=1, pulse RST_I for 1 cycle -> next cycle HCNT=0, VCNT=0, DE=1, LINE=1, FRAME=1. FRAME_O recurs every 420000 cycles. LINE_O recurs every 800 cycles.
2. Default, one line -> DE high for HCNT 0..639. HSYNC_O=0 exactly for HCNT 656..751 (96 cycles). VSYNC_O=0 exactly for VCNT 490..491. DE=0 for VCNT >= 480.
3. H_POL=1, V_POL=1 -> HSYNC_O and VSYNC_O bit-inverted vs test 2. Reset level is 0.
4. EN_I=0 for 10 cycles at HCNT=799, VCNT=524 -> all outputs hold and strobes are 0. After EN_I returns to 1: HCNT=0, VCNT=0, FRAME_O=1 on the first enabled edge.
5. Reset asserted at HCNT=300, VCNT=200 -> next cycle HCNT=799, VCNT=524, DE=0, syncs inactive. Tiny geometry H 4/1/2/1, V 3/1/1/1 wraps correctly at 8x6 totals.
6. VGA_PIPE_ALIGN_EN, PIPE_DLY=3 -> DE, syncs and strobes equal the test-2 waveforms shifted by exactly 3 cycles relative to HCNT_O. Reset clears all stages.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared geometry sets and sync polarity helpers for vga_timing_gen.
// Geometry is given per axis as display / front porch / pulse / back porch.
package vga_timing_pkg;

    typedef struct packed {
        int dispw;
        int fp;
        int pw;
        int bp;
    } axis_geom_t;

    typedef struct packed {
        axis_geom_t h;
        axis_geom_t v;
    } mode_geom_t;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    // 640x480@60 totals 800x525; 1280x960 totals 1712x994.
    localparam mode_geom_t MODE_640X480_60 = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};
    localparam mode_geom_t MODE_1280X960   = '{h: '{1280, 80, 136, 216}, v: '{960, 1, 3, 30}};

    function automatic logic sync_level(input logic pol, input logic active);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DEPTH stages, each stage resetting to rst_val.
// DEPTH of 0 degenerates to a wire.
module vga_delay_line #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        assign q = d;
    end else begin : g_stages
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
            end else if (en) begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters with registered DE, sync and strobes.
// Define VGA_PIPE_ALIGN_EN to delay DE/sync/strobes by PIPE_DLY enabled cycles (counters undelayed).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPW  = MODE_640X480_60.h.dispw,
    parameter int H_FP     = MODE_640X480_60.h.fp,
    parameter int H_PW     = MODE_640X480_60.h.pw,
    parameter int H_BP     = MODE_640X480_60.h.bp,
    parameter bit H_POL    = POL_ACTIVE_LOW,
    parameter int V_DISPW  = MODE_640X480_60.v.dispw,
    parameter int V_FP     = MODE_640X480_60.v.fp,
    parameter int V_PW     = MODE_640X480_60.v.pw,
    parameter int V_BP     = MODE_640X480_60.v.bp,
    parameter bit V_POL    = POL_ACTIVE_LOW,
    parameter int CNT_W    = 13,
    parameter int PIPE_DLY = 2
) (
    input  logic             PCLK_I,
    input  logic             RST_I,
    input  logic             EN_I,
    output logic [CNT_W-1:0] HCNT_O,
    output logic [CNT_W-1:0] VCNT_O,
    output logic             DE_O,
    output logic             HSYNC_O,
    output logic             VSYNC_O,
    output logic             LINE_O,
    output logic             FRAME_O
);

    localparam int     H_TOT     = H_DISPW + H_FP + H_PW + H_BP;
    localparam int     V_TOT     = V_DISPW + V_FP + V_PW + V_BP;
    localparam longint CNT_RANGE = 64'd1 << CNT_W;

    if (H_DISPW < 1 || H_FP < 1 || H_PW < 1 || H_BP < 1 ||
        V_DISPW < 1 || V_FP < 1 || V_PW < 1 || V_BP < 1 || PIPE_DLY < 0 ||
        longint'(H_TOT) > CNT_RANGE || longint'(V_TOT) > CNT_RANGE) begin : g_bad_param
        $error("vga_timing_gen: zero geometry or totals exceed counter range");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_DE_END = CNT_W'(H_DISPW);
    localparam logic [CNT_W-1:0] V_DE_END = CNT_W'(V_DISPW);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPW + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPW + H_FP + H_PW - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPW + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPW + V_FP + V_PW - 1);
    localparam logic             HS_IDLE  = sync_level(H_POL, 1'b0);
    localparam logic             VS_IDLE  = sync_level(V_POL, 1'b0);

    logic [CNT_W-1:0] hcnt, vcnt, h_next, v_next;
    logic             de_next, hs_next, vs_next, line_next, frame_next;
    logic             de_q, hs_q, vs_q, line_q, frame_q, en_q;
    logic [4:0]       tim_aligned, tim_out;

    always_comb begin
        h_next = hcnt + 1'b1;
        v_next = vcnt;
        if (hcnt == H_LAST) begin
            h_next = '0;
            v_next = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end
    end

    // Decoding the next count keeps every registered output in step with the counters.
    assign de_next    = (h_next < H_DE_END) && (v_next < V_DE_END);
    assign hs_next    = sync_level(H_POL, (h_next >= HS_START) && (h_next <= HS_END));
    assign vs_next    = sync_level(V_POL, (v_next >= VS_START) && (v_next <= VS_END));
    assign line_next  = (h_next == '0);
    assign frame_next = (h_next == '0) && (v_next == '0);

    always_ff @(posedge PCLK_I) begin
        if (RST_I) begin
            hcnt    <= H_LAST;
            vcnt    <= V_LAST;
            de_q    <= 1'b0;
            hs_q    <= HS_IDLE;
            vs_q    <= VS_IDLE;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            en_q <= EN_I;
            if (EN_I) begin
                hcnt    <= h_next;
                vcnt    <= v_next;
                de_q    <= de_next;
                hs_q    <= hs_next;
                vs_q    <= vs_next;
                line_q  <= line_next;
                frame_q <= frame_next;
            end
        end
    end

    assign tim_aligned = {de_q, hs_q, vs_q, line_q, frame_q};

`ifdef VGA_PIPE_ALIGN_EN
    vga_delay_line #(
        .WIDTH (5),
        .DEPTH (PIPE_DLY)
    ) u_delay_line (
        .clk     (PCLK_I),
        .rst     (RST_I),
        .en      (EN_I),
        .rst_val ({1'b0, HS_IDLE, VS_IDLE, 2'b00}),
        .d       (tim_aligned),
        .q       (tim_out)
    );
`else
    assign tim_out = tim_aligned;
`endif

    // Strobes stay stored while frozen so none is lost in the delay line; they are only masked.
    assign HCNT_O  = hcnt;
    assign VCNT_O  = vcnt;
    assign DE_O    = tim_out[4];
    assign HSYNC_O = tim_out[3];
    assign VSYNC_O = tim_out[2];
    assign LINE_O  = tim_out[1] & en_q;
    assign FRAME_O = tim_out[0] & en_q;

endmodule
